vregfile_wb_ctrl: RTL

Write-back controller for the 16-entry, 3-lane × 18-bit vector register file.
- Arbitrates the single register-file write port between two producers: requester 0 is the vector ALU, requester 1 is the load unit.
- Keeps a per-register busy scoreboard so the issue stage can stall on RAW and WAW hazards.
- Sits between the execute/memory stages and the register file's `we3/ra3/wd3` port. Read addresses `ra1/ra2` also pass through it for hazard checks.

---
 rtl/vregfile_wb_ctrl_if.sv | 25 ++
 rtl/vregfile_wb_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/vregfile_wb_ctrl_if.sv
// Producer-side channels of the vector register-file write-back controller:
// two write requesters (0 = vector ALU, 1 = load unit) and the issue-stage reservation port.
interface vregfile_wb_ctrl_if #(
    parameter int unsigned AW    = 4,
    parameter int unsigned LANES = 3,
    parameter int unsigned LW    = 18
);
    logic [1:0]                    req_valid;
    logic [1:0]                    req_ready;
    logic [1:0][AW-1:0]            req_addr;
    logic [1:0][LANES-1:0][LW-1:0] req_data;
    logic                          mark_valid;
    logic [AW-1:0]                 mark_addr;
    logic                          mark_ready;

    modport master (
        output req_valid, req_addr, req_data, mark_valid, mark_addr,
        input  req_ready, mark_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data, mark_valid, mark_addr,
        output req_ready, mark_ready
    );
endinterface

// File: rtl/vregfile_wb_ctrl.sv
// Write-back controller: round-robin arbitration of the register-file write port plus a busy
// scoreboard for RAW/WAW stalls. Define VREGFILE_WB_BYPASS_EN to forward the write stage to reads.
module vregfile_wb_ctrl #(
    parameter int unsigned NREG  = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned LANES = 3,
    parameter int unsigned LW    = 18
) (
    input  logic                          clk,
    input  logic                          rst_n,
    vregfile_wb_ctrl_if.slave             wb,
    input  logic [AW-1:0]                 ra1,
    input  logic [AW-1:0]                 ra2,
    output logic                          src_stall,
    input  logic [LANES-1:0][LW-1:0]      rd1_in,
    input  logic [LANES-1:0][LW-1:0]      rd2_in,
    output logic [LANES-1:0][LW-1:0]      rd1_out,
    output logic [LANES-1:0][LW-1:0]      rd2_out,
    output logic                          we3,
    output logic [AW-1:0]                 ra3,
    output logic [LANES-1:0][LW-1:0]      wd3,
    output logic [NREG-1:0]               busy,
    output logic                          err_orphan
);

    typedef logic [LANES-1:0][LW-1:0] vec_t;

    logic            last_q, last_d;
    logic [1:0]      grant;
    logic            xfer;
    logic            xfer_idx;
    logic [AW-1:0]   xfer_addr;
    vec_t            xfer_data;

    logic            we3_q, we3_d;
    logic [AW-1:0]   ra3_q, ra3_d;
    vec_t            wd3_q, wd3_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            orphan_q, orphan_d;
    logic            mark_fire;

    // last_q holds the most recent winner; on a tie the other requester goes next.
    always_comb begin
        grant = 2'b00;
        unique case (wb.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign wb.req_ready = grant;
    assign xfer         = |grant;
    assign xfer_idx     = grant[1];
    assign xfer_addr    = wb.req_addr[xfer_idx];
    assign xfer_data    = wb.req_data[xfer_idx];

    assign wb.mark_ready = ~busy_q[wb.mark_addr];
    assign mark_fire     = wb.mark_valid & wb.mark_ready;

    always_comb begin
        last_d   = last_q;
        we3_d    = xfer;
        ra3_d    = ra3_q;
        wd3_d    = wd3_q;
        orphan_d = orphan_q;
        busy_d   = busy_q;

        if (xfer) begin
            last_d = xfer_idx;
            ra3_d  = xfer_addr;
            wd3_d  = xfer_data;
            if (!busy_q[xfer_addr]) begin
                orphan_d = 1'b1;
            end
        end

        // Clear lands on the register-file write edge; mark_ready keeps set and clear disjoint.
        if (we3_q) begin
            busy_d[ra3_q] = 1'b0;
        end
        if (mark_fire) begin
            busy_d[wb.mark_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= 1'b1;
            we3_q    <= 1'b0;
            ra3_q    <= '0;
            wd3_q    <= '0;
            busy_q   <= '0;
            orphan_q <= 1'b0;
        end else begin
            last_q   <= last_d;
            we3_q    <= we3_d;
            ra3_q    <= ra3_d;
            wd3_q    <= wd3_d;
            busy_q   <= busy_d;
            orphan_q <= orphan_d;
        end
    end

    assign we3        = we3_q;
    assign ra3        = ra3_q;
    assign wd3        = wd3_q;
    assign busy       = busy_q;
    assign err_orphan = orphan_q;

`ifdef VREGFILE_WB_BYPASS_EN
    logic hit1, hit2;

    // A source being written this cycle is served from the write stage instead of stalling.
    assign hit1      = we3_q && (ra3_q == ra1);
    assign hit2      = we3_q && (ra3_q == ra2);
    assign src_stall = (busy_q[ra1] & ~hit1) | (busy_q[ra2] & ~hit2);
    assign rd1_out   = hit1 ? wd3_q : rd1_in;
    assign rd2_out   = hit2 ? wd3_q : rd2_in;
`else
    assign src_stall = busy_q[ra1] | busy_q[ra2];
    assign rd1_out   = rd1_in;
    assign rd2_out   = rd2_in;
`endif

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(wb.req_ready));

    a_grant_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (wb.req_ready & ~wb.req_valid) == 2'b00);

endmodule
